// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling UART receiver (8 data bits, LSB first, 1 stop).
// Define UART_RX_PARITY_EN to add a parity bit; PARITY_ODD selects odd/even.
module uart_rx_sampler #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rdy_clr,
    output logic [7:0] dout,
    output logic       rdy,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = $clog2(DIV) + 1;
    localparam int SC_W  = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [SC_W-1:0]  SC_HALF  = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);

    if (DIV < 1) begin : g_div_chk
        $error("uart_rx_sampler: CLK_HZ/(BAUD*OVERSAMPLE) must be >= 1");
    end
    if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : g_os_chk
        $error("uart_rx_sampler: OVERSAMPLE must be even and >= 8");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic              rx_meta_q, rx_meta_d;
    logic              rx_s_q, rx_s_d;
    logic              rx_prev_q, rx_prev_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [SC_W-1:0]   sample_q, sample_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        dout_q, dout_d;
    logic              rdy_q, rdy_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;
    logic              tick;
`ifdef UART_RX_PARITY_EN
    logic              par_q, par_d;
    logic              perr_q, perr_d;
    logic              par_bad;
`endif

    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        rx_prev_d = rx_s_q;
        tick      = (div_q == DIV_LAST);
        div_d     = tick ? '0 : div_q + DIV_W'(1);
        state_d   = state_q;
        sample_d  = sample_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        dout_d    = dout_q;
        rdy_d     = rdy_q;
        ferr_d    = ferr_q;
        ovr_d     = ovr_q;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
        perr_d    = perr_q;
        par_bad   = (par_q != ((^shift_q) ^ PARITY_ODD));
`endif

        // A completing good byte below overrides this clear of rdy.
        if (rdy_clr) begin
            rdy_d  = 1'b0;
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_d = 1'b0;
`endif
        end

        unique case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d  = S_START;
                    sample_d = '0;
                    div_d    = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (sample_q == SC_HALF) begin
                        if (rx_s_q) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d  = S_DATA;
                            sample_d = '0;
                            bit_d    = '0;
                        end
                    end else begin
                        sample_d = sample_q + SC_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (sample_q == SC_LAST) begin
                        sample_d = '0;
                        shift_d  = {rx_s_q, shift_q[7:1]};
                        bit_d    = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end else begin
                        sample_d = sample_q + SC_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    if (sample_q == SC_LAST) begin
                        sample_d = '0;
                        par_d    = rx_s_q;
                        state_d  = S_STOP;
                    end else begin
                        sample_d = sample_q + SC_W'(1);
                    end
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (sample_q == SC_LAST) begin
                        sample_d = '0;
                        state_d  = S_IDLE;
                        if (!rx_s_q) begin
                            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad) begin
                            perr_d = 1'b1;
`endif
                        end else begin
                            dout_d = shift_q;
                            rdy_d  = 1'b1;
                            if (rdy_q && !rdy_clr) begin
                                ovr_d = 1'b1;
                            end
                        end
                    end else begin
                        sample_d = sample_q + SC_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= S_IDLE;
            div_q     <= '0;
            sample_q  <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            dout_q    <= '0;
            rdy_q     <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            rx_prev_q <= rx_prev_d;
            state_q   <= state_d;
            div_q     <= div_d;
            sample_q  <= sample_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            dout_q    <= dout_d;
            rdy_q     <= rdy_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign dout      = dout_q;
    assign rdy       = rdy_q;
    assign busy      = (state_q != S_IDLE);
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: scoreboard bench for uart_rx_sampler at DIV=1 (16 clk/bit).
// Directed spec scenarios followed by randomized frames.
module tb_uart_rx_sampler;

    localparam int CLK_HZ = 1_843_200;
    localparam int BAUD   = 115200;
    localparam int OS     = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_MIN = 169;
    localparam int LAT_MAX = 171;
`else
    localparam int LAT_MIN = 153;
    localparam int LAT_MAX = 155;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rdy_clr = 1'b0;
    logic [7:0] dout;
    logic       rdy;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    uart_rx_sampler #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rdy_clr   (rdy_clr),
        .dout      (dout),
        .rdy       (rdy),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        int         t0;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         total = 0;
    int         bad = 0;
    bit         auto_ack = 1'b1;
    int         clr_req = 0;
    int         clr_done = 0;
    logic [7:0] last_good = 8'h00;
    int         lat;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_neg(int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame on rx; a good frame with push queues its expected byte.
    task automatic send(logic [7:0] d, bit stop, bit push, bit flip);
        exp_t x;
        @(negedge clk);
        rx = 1'b0;
        x.d = d;
        x.t0 = cyc;
        if (push) q.push_back(x);
        wait_neg(OS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_neg(OS);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ flip;
        wait_neg(OS);
`endif
        rx = stop;
        wait_neg(OS);
        rx = 1'b1;
    endtask

    // Monitor: consumes each presented byte, checks it, then acknowledges.
    initial begin
        forever begin
            @(negedge clk);
            rdy_clr = 1'b0;
            if (rdy && auto_ack && rst_n) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %0h want none", dout);
                end else begin
                    e = q.pop_front();
                    chk("dout", int'(dout), int'(e.d));
                    chk("no_overrun", int'(overrun), 0);
                    lat = cyc - e.t0;
                    total++;
                    if (lat < LAT_MIN || lat > LAT_MAX) begin
                        bad++;
                        $display("FAIL latency: got %0d want %0d..%0d",
                                 lat, LAT_MIN, LAT_MAX);
                    end
                end
                rdy_clr = 1'b1;
            end else if (clr_req != clr_done) begin
                clr_done = clr_req;
                rdy_clr = 1'b1;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        bit         ok;
        int         n;

        wait_neg(3);
        chk("rst_dout", int'(dout), 0);
        chk("rst_rdy", int'(rdy), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ferr", int'(frame_err), 0);
        chk("rst_ovr", int'(overrun), 0);
        chk("rst_perr", int'(parity_err), 0);
        rst_n = 1'b1;
        wait_neg(4);

        send(8'h41, 1'b1, 1'b1, 1'b0);
        last_good = 8'h41;
        wait_neg(3);
        chk("a_rdy_clr", int'(rdy), 0);
        chk("a_busy", int'(busy), 0);
        chk("a_dout", int'(dout), 8'h41);

        auto_ack = 1'b0;
        send(8'h30, 1'b1, 1'b0, 1'b0);
        send(8'h46, 1'b1, 1'b0, 1'b0);
        last_good = 8'h46;
        wait_neg(2);
        chk("ovr_dout", int'(dout), 8'h46);
        chk("ovr_rdy", int'(rdy), 1);
        chk("ovr_flag", int'(overrun), 1);
        clr_req++;
        wait_neg(3);
        chk("ovr_clr_rdy", int'(rdy), 0);
        chk("ovr_clr_flag", int'(overrun), 0);
        auto_ack = 1'b1;

        send(8'h55, 1'b0, 1'b0, 1'b0);
        chk("fe_flag", int'(frame_err), 1);
        chk("fe_rdy", int'(rdy), 0);
        chk("fe_dout", int'(dout), int'(last_good));
        clr_req++;
        wait_neg(3);
        chk("fe_clr", int'(frame_err), 0);
        send(8'h31, 1'b1, 1'b1, 1'b0);
        last_good = 8'h31;
        wait_neg(3);

        @(negedge clk);
        rx = 1'b0;
        wait_neg(5);
        chk("gl_busy", int'(busy), 1);
        wait_neg(1);
        rx = 1'b1;
        wait_neg(20);
        chk("gl_idle", int'(busy), 0);
        chk("gl_rdy", int'(rdy), 0);
        chk("gl_ferr", int'(frame_err), 0);
        send(8'h39, 1'b1, 1'b1, 1'b0);
        last_good = 8'h39;
        wait_neg(3);

        d = 8'hA5;
        @(negedge clk);
        rx = 1'b0;
        wait_neg(OS);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            wait_neg(OS);
        end
        rx = d[4];
        wait_neg(OS / 2);
        rst_n = 1'b0;
        wait_neg(1);
        chk("mr_dout", int'(dout), 0);
        chk("mr_rdy", int'(rdy), 0);
        chk("mr_busy", int'(busy), 0);
        chk("mr_ferr", int'(frame_err), 0);
        rx = 1'b1;
        wait_neg(2);
        rst_n = 1'b1;
        last_good = 8'h00;
        wait_neg(5);
        chk("mr_no_partial", int'(rdy), 0);
        send(8'hA5, 1'b1, 1'b1, 1'b0);
        last_good = 8'hA5;
        wait_neg(3);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1, 1'b0);
        last_good = 8'h07;
        wait_neg(3);
        send(8'h07, 1'b1, 1'b0, 1'b1);
        chk("pe_flag", int'(parity_err), 1);
        chk("pe_rdy", int'(rdy), 0);
        chk("pe_dout", int'(dout), int'(last_good));
        clr_req++;
        wait_neg(3);
        chk("pe_clr", int'(parity_err), 0);
`endif

        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            send(d, ok, ok, 1'b0);
            if (!ok) begin
                chk("rnd_ferr", int'(frame_err), 1);
                chk("rnd_fe_rdy", int'(rdy), 0);
                chk("rnd_fe_dout", int'(dout), int'(last_good));
                clr_req++;
                wait_neg(3);
            end else begin
                last_good = d;
                chk("rnd_ferr0", int'(frame_err), 0);
            end
            wait_neg($urandom_range(0, 20));
        end

        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", q.size(), 0);
        chk("end_perr", int'(parity_err), 0);
        chk("end_ovr", int'(overrun), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
